// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
package mux_scan_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Select width for a given channel count, never narrower than one bit.
    function automatic int sel_width(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_scan_timer.sv
// Dwell counter for the scan mode: counts enabled cycles on the current channel
// and emits a one-cycle advance once the count reaches the programmed dwell.
module mux_scan_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               clear,
    input  logic               hold,
    input  logic [DWELL_W-1:0] dwell,
    output logic               advance
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Greater-or-equal so a dwell shortened below the running count advances at once.
    always_comb begin
        advance = 1'b0;
        cnt_d   = cnt_q;
        if (ena) begin
            if (clear) begin
                cnt_d = '0;
            end else if (!hold) begin
                if (cnt_q >= dwell) begin
                    advance = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel registered multiplexer with manual select and timed auto-scan.
// Optional even-parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 8,
    parameter  int DWELL_W  = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      sel_load,
    input  logic                      hold,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_switch,
    output logic                      sel_err
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    localparam logic [SEL_W:0]   CH_COUNT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

    mode_e              mode_in;
    mode_e              mode_q;
    logic [SEL_W-1:0]   cur_sel_q;
    logic [SEL_W-1:0]   cur_sel_d;
    logic [WIDTH-1:0]   out_data_q;
    logic [WIDTH-1:0]   out_data_d;
    logic [SEL_W-1:0]   out_sel_q;
    logic [SEL_W-1:0]   out_sel_d;
    logic               out_switch_q;
    logic               out_switch_d;
    logic               sel_err_q;
    logic               sel_err_d;

    logic [WIDTH-1:0]   ch_word [CHANNELS];
    logic [WIDTH-1:0]   selected;
    logic               sel_ok;
    logic               load_ok;
    logic               load_bad;
    logic               mode_chg;
    logic               scan_on;
    logic               timer_clear;
    logic               timer_hold;
    logic               advance;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign ch_word[gi] = ch_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        selected = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cur_sel_q == SEL_W'(i)) begin
                selected = ch_word[i];
            end
        end
    end

    assign mode_in  = mode_e'(mode);
    assign sel_ok   = ({1'b0, sel_in} < CH_COUNT);
    assign load_ok  = sel_load && sel_ok;
    assign load_bad = sel_load && !sel_ok;
    assign mode_chg = (mode_in != mode_q);
    assign scan_on  = (mode_in == MODE_SCAN);

    // Any load (even a rejected one) outranks the scan advance for that cycle.
    assign timer_clear = load_ok || mode_chg || !scan_on;
    assign timer_hold  = hold || sel_load;

    mux_scan_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .clear   (timer_clear),
        .hold    (timer_hold),
        .dwell   (dwell),
        .advance (advance)
    );

    always_comb begin
        cur_sel_d    = cur_sel_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_switch_d = 1'b0;
        sel_err_d    = 1'b0;
        if (ena) begin
            if (load_ok) begin
                cur_sel_d = sel_in;
            end else if (advance) begin
                cur_sel_d = (cur_sel_q == LAST_SEL) ? '0 : cur_sel_q + SEL_W'(1);
            end
            out_data_d   = selected;
            out_sel_d    = cur_sel_q;
            out_switch_d = (cur_sel_q != out_sel_q);
            sel_err_d    = load_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= MODE_MANUAL;
            cur_sel_q    <= '0;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_switch_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            if (ena) begin
                mode_q <= mode_in;
            end
            cur_sel_q    <= cur_sel_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_switch_q <= out_switch_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_sel    = out_sel_q;
    assign out_switch = out_switch_q;
    assign sel_err    = sel_err_q;

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (ena) begin
            parity_q <= ^out_data_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench: a 4-channel instance driven from a vector table, plus a
// 3-channel instance for out-of-range loads and scan/load priority.
module tb_mux_scan_sel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [31:0] ch_data4;
    logic [23:0] ch_data3;
    logic        mode;
    logic [1:0]  sel_in;
    logic        sel_load;
    logic        hold;
    logic [3:0]  dwell;

    logic [7:0]  out_data4, out_data3;
    logic [1:0]  out_sel4, out_sel3;
    logic        out_switch4, out_switch3;
    logic        sel_err4, sel_err3;
`ifdef MUX_SCAN_PARITY_EN
    logic        out_parity4, out_parity3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_sel #(.CHANNELS(4), .WIDTH(8), .DWELL_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ch_data    (ch_data4),
        .mode       (mode),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .hold       (hold),
        .dwell      (dwell),
        .out_data   (out_data4),
        .out_sel    (out_sel4),
        .out_switch (out_switch4),
        .sel_err    (sel_err4)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_parity (out_parity4)
`endif
    );

    mux_scan_sel #(.CHANNELS(3), .WIDTH(8), .DWELL_W(4)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ch_data    (ch_data3),
        .mode       (mode),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .hold       (hold),
        .dwell      (dwell),
        .out_data   (out_data3),
        .out_sel    (out_sel3),
        .out_switch (out_switch3),
        .sel_err    (sel_err3)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_parity (out_parity3)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic       mode;
        logic [1:0] sel_in;
        logic       sel_load;
        logic       hold;
        logic [3:0] dwell;
        logic [7:0] exp_data;
        logic [1:0] exp_sel;
        logic       exp_switch;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic m,
                                input logic [1:0] s, input logic ld, input logic h,
                                input logic [3:0] d, input logic [7:0] xd,
                                input logic [1:0] xs, input logic xw);
        vec_t v;
        v.rst_n = r; v.ena = e; v.mode = m; v.sel_in = s; v.sel_load = ld;
        v.hold = h; v.dwell = d; v.exp_data = xd; v.exp_sel = xs; v.exp_switch = xw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic log3(input string label);
        $display("%s: dut3 data=%02h sel=%0d sw=%0b err=%0b | dut4 data=%02h sel=%0d",
                 label, out_data3, out_sel3, out_switch3, sel_err3, out_data4, out_sel4);
    endtask

    initial begin
        // rst, ena, mode, sel_in, load, hold, dwell | data, sel, switch
        vecs.push_back(mk(0,1,0,0,0,0,0, 8'h00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 8'h00,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,0,2,1,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h33,2,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h33,2,0));
        vecs.push_back(mk(1,1,0,2,1,0,0, 8'h33,2,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h33,2,0));
        vecs.push_back(mk(1,1,0,3,1,0,0, 8'h33,2,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h44,3,1));
        vecs.push_back(mk(1,1,0,0,1,0,0, 8'h44,3,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h11,0,1));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h11,0,0));   // mode change: count restarts
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h22,1,1));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h22,1,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h22,1,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h33,2,1));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h33,2,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h33,2,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h44,3,1));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h44,3,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h44,3,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h11,0,1));   // wrap 3 -> 0
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h11,0,0));   // dwell cut below count
        vecs.push_back(mk(1,1,1,0,0,1,0, 8'h22,1,1));   // hold on channel 1
        vecs.push_back(mk(1,1,1,0,0,1,0, 8'h22,1,0));
        vecs.push_back(mk(1,1,1,0,0,1,0, 8'h22,1,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h22,1,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h33,2,1));
        vecs.push_back(mk(1,1,1,1,1,0,0, 8'h44,3,1));   // load beats advance
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h22,1,1));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h33,2,1));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h33,2,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h33,2,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,1,0,0,0,2, 8'h33,2,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h44,3,1));   // resumes with count kept
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h44,3,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h44,3,0));
        vecs.push_back(mk(1,1,1,0,0,0,2, 8'h11,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h22,1,1));
        vecs.push_back(mk(0,1,1,0,0,0,0, 8'h00,0,0));   // reset mid-scan
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h11,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 8'h22,1,1));

        ch_data4 = 32'h44332211;
        ch_data3 = 24'h07B2A1;
        rst_n = 1'b0; ena = 1'b1; mode = 1'b0; sel_in = '0;
        sel_load = 1'b0; hold = 1'b0; dwell = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst_n;
            ena      = vecs[i].ena;
            mode     = vecs[i].mode;
            sel_in   = vecs[i].sel_in;
            sel_load = vecs[i].sel_load;
            hold     = vecs[i].hold;
            dwell    = vecs[i].dwell;
            step();
            $display("vec %0d: data=%02h sel=%0d sw=%0b err=%0b", i,
                     out_data4, out_sel4, out_switch4, sel_err4);
            check($sformatf("vec%0d_data", i), 32'(out_data4), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_sel", i), 32'(out_sel4), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_switch", i), 32'(out_switch4), 32'(vecs[i].exp_switch));
            check($sformatf("vec%0d_err", i), 32'(sel_err4), 32'(0));
        end

        // Reset and data latency / freeze with changing channel data.
        mode = 1'b0; hold = 1'b0; dwell = '0; sel_load = 1'b0; sel_in = '0; ena = 1'b1;
        rst_n = 1'b0; step(); log3("reset");
        check("rst_data3", 32'(out_data3), 32'h00);
        check("rst_sel3", 32'(out_sel3), 32'd0);
        check("rst_err3", 32'(sel_err3), 32'd0);
        rst_n = 1'b1; step(); log3("release");
        check("rel_data3", 32'(out_data3), 32'hA1);
        check("rel_data4", 32'(out_data4), 32'h11);
        ch_data4[7:0] = 8'h5A; step(); log3("data_lat");
        check("lat_data4", 32'(out_data4), 32'h5A);
        ena = 1'b0; ch_data4[7:0] = 8'h6B; step(); log3("ena_low");
        check("frz_data4", 32'(out_data4), 32'h5A);
        ena = 1'b1; step(); log3("ena_high");
        check("unfrz_data4", 32'(out_data4), 32'h6B);
`ifdef MUX_SCAN_PARITY_EN
        check("parity_6b", 32'(out_parity4), 32'd1);
`endif

        // Out-of-range load on the 3-channel instance.
        sel_load = 1'b1; sel_in = 2'd1; step(); log3("load1");
        check("ld1_sel3", 32'(out_sel3), 32'd0);
        sel_load = 1'b0; step(); log3("idle");
        check("ld1_out_sel3", 32'(out_sel3), 32'd1);
        check("ld1_data3", 32'(out_data3), 32'hB2);
        check("ld1_switch3", 32'(out_switch3), 32'd1);
        sel_load = 1'b1; sel_in = 2'd3; step(); log3("load3_bad");
        check("bad_err3", 32'(sel_err3), 32'd1);
        check("bad_sel3", 32'(out_sel3), 32'd1);
        check("bad_switch3", 32'(out_switch3), 32'd0);
        sel_load = 1'b0; step(); log3("idle");
        check("bad_err3_pulse", 32'(sel_err3), 32'd0);
        check("bad_sel3_kept", 32'(out_sel3), 32'd1);

        // Scan with dwell 0: load and rejected load both pre-empt the advance.
        mode = 1'b1; dwell = '0; step(); log3("scan_on");
        check("scan_on_sel3", 32'(out_sel3), 32'd1);
        sel_load = 1'b1; sel_in = 2'd0; step(); log3("load0_scan");
        sel_load = 1'b0; step(); log3("after_load0");
        check("win_sel3", 32'(out_sel3), 32'd0);
        check("win_data3", 32'(out_data3), 32'hA1);
        check("win_switch3", 32'(out_switch3), 32'd1);
        sel_load = 1'b1; sel_in = 2'd3; step(); log3("bad_in_scan");
        check("scan_bad_err3", 32'(sel_err3), 32'd1);
        check("scan_bad_sel3", 32'(out_sel3), 32'd1);
        sel_load = 1'b0; step(); log3("after_bad");
        check("scan_bad_hold_sel3", 32'(out_sel3), 32'd1);
        check("scan_bad_switch3", 32'(out_switch3), 32'd0);
        step(); log3("advance");
        check("adv_sel3", 32'(out_sel3), 32'd2);
        check("adv_data3", 32'(out_data3), 32'h07);
`ifdef MUX_SCAN_PARITY_EN
        check("parity_07", 32'(out_parity3), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
